// File: rtl/uart_baud_cnt.sv
// Loadable baud-rate down-counter; expired is high while the count sits at zero.
// Shared by the UART receive and transmit units.
module uart_baud_cnt #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load wins over the expiry cycle so the next interval starts without a gap.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with mid-bit sampling, framing-error and break handling.
// Define UART_RX_PARITY_EN for 8E1 frames with an rx_parity_err output.
module uart_rx_unit #(
    parameter int clk_freq = 12_000_000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int DIV   = clk_freq / baud;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

    if (DIV < 8) begin : g_bad_div
        $error("uart_rx_unit: clk_freq/baud must be at least 8");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, sync2_q;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_ready_q, rx_ready_d;
    logic       frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic       par_bit_q, par_bit_d;
    logic       parity_err_q, parity_err_d;
`endif

    logic             rxs;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_exp;

    assign rxs = sync2_q;

    uart_baud_cnt #(.CNT_W(CNT_W)) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expired  (cnt_exp)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = DIV_M1;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_load = 1'b1;
                    cnt_val  = HALF_M1;
                    state_d  = START;
                end
            end
            START: begin
                if (cnt_exp) begin
                    if (!rxs) begin
                        cnt_load  = 1'b1;
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_exp) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    cnt_load  = 1'b1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_exp) begin
                    par_bit_d = rxs;
                    cnt_load  = 1'b1;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // A low stop bit takes precedence over any parity result.
                if (cnt_exp) begin
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        if ((^shift_q) ^ par_bit_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_data_d  = shift_q;
                            rx_ready_d = 1'b1;
                        end
`else
                        rx_data_d  = shift_q;
                        rx_ready_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_ready     = rx_ready_q;
    assign rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed plus randomized checks of uart_rx_unit against a frame-level model.
// Build with UART_RX_PARITY_EN defined to cover the 8E1 variant.
module tb_uart_rx_unit;

    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 155 + DIV;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    uart_rx_unit #(.clk_freq(1_600_000), .baud(100_000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int ready_cnt = 0, ferr_cnt = 0, perr_cnt = 0, both_cnt = 0, data_glitch = 0;
    int exp_ferr = 0, exp_perr = 0;
    int last_ready_cyc = 0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] last_good = 8'd0;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_ready === 1'b1) begin
                got_q.push_back(rx_data);
                ready_cnt++;
                last_ready_cyc = cyc;
            end
            if (rx_frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (rx_parity_err === 1'b1) perr_cnt++;
            if (rx_parity_err === 1'b1 && (rx_ready === 1'b1 || rx_frame_err === 1'b1)) both_cnt++;
`endif
            if (rx_ready === 1'b1 && rx_frame_err === 1'b1) both_cnt++;
            if (rx_data !== prev_data && rx_ready !== 1'b1) data_glitch++;
        end
        prev_data = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cyc(DIV);
    endtask

    // Reference model: a frame is good only with a high stop bit (and correct parity).
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_b);
        if (!stop_b) exp_ferr++;
`ifdef UART_RX_PARITY_EN
        else if (!par_ok) exp_perr++;
`endif
        else begin
            exp_q.push_back(d);
            last_good = d;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ !par_ok);
`endif
        drive_bit(stop_b);
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) check({tag, "_missing"}, 32'hDEAD, {24'd0, e});
            else check({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, e});
        end
        check({tag, "_extra"}, got_q.size(), 0);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_perr"}, perr_cnt, exp_perr);
        check({tag, "_overlap"}, both_cnt, 0);
        check({tag, "_data_glitch"}, data_glitch, 0);
        check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, last_good});
        got_q.delete();
    endtask

    initial begin
        int start_cyc;
        logic [7:0] d;
        bit bad_stop, par_ok;

        // Reset with idle line.
        rx = 1'b1;
        rst_n = 1'b0;
        wait_cyc(5);
        check("reset_rx_data", {24'd0, rx_data}, 0);
        check("reset_rx_ready", {31'd0, rx_ready}, 0);
        check("reset_frame_err", {31'd0, rx_frame_err}, 0);
        rst_n = 1'b1;
        wait_cyc(100);
        check("post_reset_ready", ready_cnt, 0);
        check("post_reset_ferr", ferr_cnt, 0);

        // Single byte with latency measurement.
        start_cyc = cyc;
        send_frame(8'h41, 1'b1, 1'b1);
        wait_cyc(5);
        check("single_count", ready_cnt, 1);
        check("single_latency_ok",
              {31'd0, ((last_ready_cyc - start_cyc) >= LAT - 2) && ((last_ready_cyc - start_cyc) <= LAT + 2)}, 1);
        check_all("single");

        // Back-to-back frames with no idle gap.
        send_frame(8'h0D, 1'b1, 1'b1);
        send_frame(8'h08, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_cyc(5);
        check_all("b2b");

        // Short start glitch, then a real frame.
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(3 * DIV);
        check("glitch_no_ready", ready_cnt, 4);
        send_frame(8'h55, 1'b1, 1'b1);
        wait_cyc(5);
        check_all("glitch");

        // Framing error followed by a long break.
        send_frame(8'h33, 1'b1, 1'b0);
        wait_cyc(40 * DIV);
        check("break_single_ferr", ferr_cnt, 1);
        rx = 1'b1;
        wait_cyc(2 * DIV);
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_cyc(5);
        check_all("break");

        // Reset during data bit 4 of 0xA5.
        d = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        wait_cyc(DIV / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        last_good = 8'h00;
        wait_cyc(12 * DIV);
        check_all("mid_reset");
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_cyc(5);
        check_all("after_reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_cyc(5);
        check_all("parity");
`endif

        // Randomized frames, gaps and framing errors.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            bad_stop = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
            par_ok = ($urandom_range(0, 4) != 0);
`else
            par_ok = 1'b1;
`endif
            send_frame(d, par_ok, !bad_stop);
            rx = 1'b1;
            if (bad_stop) wait_cyc(DIV + $urandom_range(2, DIV));
            else if ($urandom_range(0, 1) == 1) wait_cyc($urandom_range(1, 20));
        end
        wait_cyc(5);
        check_all("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
